obi_slave_bridge: RTL

OBI responder that terminates one slave port of the system bus and drives a simple valid/ready command channel plus an in-order response channel toward a multi-cycle peripheral (flash controller, external-bus adapter, slow register blocks). It decouples OBI grant from peripheral acceptance and tracks up to OUTSTANDING in-flight transactions. It returns exactly one OBI response per grant, in grant order. It sits between a slave port of the OBI interconnect and the peripheral.

---
 rtl/obi_pkg.sv | 17 +
 rtl/obi_bridge_timeout.sv | 52 +++++
 rtl/obi_slave_bridge.sv | 138 +++++++++++++
 3 files changed

// File: rtl/obi_pkg.sv
// Shared command type, error data word and counter-width helper for the OBI slave bridge.
package obi_pkg;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_cmd_t;

  localparam logic [31:0] OBI_ERR_RDATA = 32'hDEAD_BEEF;

  function automatic int obi_cnt_width(input int max_count);
    return $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/obi_bridge_timeout.sv
// Response-wait timer for the oldest outstanding transaction, plus a counter of late
// peripheral responses to swallow after a timed-out transaction was already answered.
module obi_bridge_timeout
  import obi_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CW      = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic busy_i,
  input  logic capture_i,
  input  logic per_rvalid_i,
  input  logic discard_inc_i,
  output logic timeout_o,
  output logic swallow_o
);

  localparam int            TW      = obi_cnt_width(TIMEOUT);
  localparam logic [TW-1:0] T_LIMIT = TW'(TIMEOUT);

  logic [TW-1:0] timer_r;
  logic [CW-1:0] discard_r;
  logic          discard_nz_s;

  assign discard_nz_s = (discard_r != {CW{1'b0}});
  assign swallow_o    = per_rvalid_i && discard_nz_s;
  assign timeout_o    = busy_i && (timer_r == T_LIMIT) && !per_rvalid_i;

  // Age of the oldest transaction; restarts whenever the oldest one changes, saturates at the limit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      timer_r <= {TW{1'b0}};
    end else if (!busy_i || capture_i || timeout_o) begin
      timer_r <= {TW{1'b0}};
    end else if (timer_r != T_LIMIT) begin
      timer_r <= timer_r + TW'(1'b1);
    end
  end

  // Count responses still owed by the peripheral for transactions already answered with an error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      discard_r <= {CW{1'b0}};
    end else if (discard_inc_i && (discard_r != {CW{1'b1}})) begin
      discard_r <= discard_r + CW'(1'b1);
    end else if (swallow_o) begin
      discard_r <= discard_r - CW'(1'b1);
    end
  end

endmodule

// File: rtl/obi_slave_bridge.sv
// OBI responder driving a valid/ready peripheral command channel with in-order responses.
// Optional response timeout with error replies: define OBI_BRIDGE_TIMEOUT_EN.
module obi_slave_bridge
  import obi_pkg::*;
#(
  parameter int OUTSTANDING = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        per_valid_o,
  input  logic        per_ready_i,
  output logic        per_we_o,
  output logic [3:0]  per_be_o,
  output logic [31:0] per_addr_o,
  output logic [31:0] per_wdata_o,
  input  logic        per_rvalid_i,
  input  logic [31:0] per_rdata_i
);

  localparam int            CW      = obi_cnt_width(OUTSTANDING);
  localparam logic [CW-1:0] OUT_MAX = CW'(OUTSTANDING);

  obi_cmd_t      cmd_q;
  logic          cmd_valid_q;
  logic [CW-1:0] outstanding_q;
  logic          rvalid_r;
  logic          err_r;
  logic [31:0]   rdata_r;

  logic accept_s;
  logic handshake_s;
  logic busy_s;
  logic capture_s;
  logic timeout_s;
  logic swallow_s;
  logic withdraw_s;
  logic out_inc_s;
  logic out_dec_s;

  assign gnt_o       = (!cmd_valid_q || per_ready_i) && (outstanding_q < OUT_MAX);
  assign accept_s    = req_i && gnt_o;
  assign handshake_s = cmd_valid_q && per_ready_i;
  assign busy_s      = (outstanding_q != {CW{1'b0}});
  assign capture_s   = per_rvalid_i && busy_s && !swallow_s;

`ifdef OBI_BRIDGE_TIMEOUT_EN
  logic discard_inc_s;

  obi_bridge_timeout #(
    .TIMEOUT (TIMEOUT),
    .CW      (CW)
  ) u_timeout (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .busy_i        (busy_s),
    .capture_i     (capture_s),
    .per_rvalid_i  (per_rvalid_i),
    .discard_inc_i (discard_inc_s),
    .timeout_o     (timeout_s),
    .swallow_o     (swallow_s)
  );

  // The oldest transaction sits in the command stage only if it is the sole one and not handshaking now.
  assign withdraw_s    = timeout_s && cmd_valid_q && (outstanding_q == CW'(1'b1)) && !per_ready_i;
  assign discard_inc_s = timeout_s && !withdraw_s;
`else
  logic [31:0] unused_timeout_s;

  assign timeout_s        = 1'b0;
  assign swallow_s        = 1'b0;
  assign withdraw_s       = 1'b0;
  assign unused_timeout_s = 32'(TIMEOUT);
`endif

  assign out_inc_s = accept_s;
  assign out_dec_s = capture_s || timeout_s;

  // Command stage: load on grant, hold until the peripheral takes it (or it is withdrawn).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cmd_valid_q <= 1'b0;
      cmd_q       <= '{we: 1'b0, be: 4'h0, addr: 32'h0000_0000, wdata: 32'h0000_0000};
    end else if (accept_s) begin
      cmd_valid_q <= 1'b1;
      cmd_q       <= '{we: we_i, be: be_i, addr: addr_i, wdata: wdata_i};
    end else if (handshake_s || withdraw_s) begin
      cmd_valid_q <= 1'b0;
    end
  end

  // Granted-but-unanswered count; a grant and a response in the same cycle cancel out.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outstanding_q <= {CW{1'b0}};
    end else if (out_inc_s && !out_dec_s) begin
      outstanding_q <= outstanding_q + CW'(1'b1);
    end else if (!out_inc_s && out_dec_s) begin
      outstanding_q <= outstanding_q - CW'(1'b1);
    end
  end

  // Registered OBI response: one-cycle rvalid pulse, rdata holds between responses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_r <= 1'b0;
      err_r    <= 1'b0;
      rdata_r  <= 32'h0000_0000;
    end else begin
      rvalid_r <= capture_s || timeout_s;
      err_r    <= timeout_s;
      if (capture_s) begin
        rdata_r <= per_rdata_i;
      end else if (timeout_s) begin
        rdata_r <= OBI_ERR_RDATA;
      end
    end
  end

  assign rvalid_o    = rvalid_r;
  assign rdata_o     = rdata_r;
  assign err_o       = err_r;
  assign per_valid_o = cmd_valid_q;
  assign per_we_o    = cmd_q.we;
  assign per_be_o    = cmd_q.be;
  assign per_addr_o  = cmd_q.addr;
  assign per_wdata_o = cmd_q.wdata;

endmodule
